// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: shared definitions for the SPARC memory stage.
//   - access-size encodings carried by mem_access_size
//   - trap cause encodings reported on trap_cause
//   - load/store unit FSM state encoding
//   - alignment helper used at bundle accept
package sparc_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } lsu_state_e;

  // True when the low effective-address bits violate natural alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] ea_lo);
    unique case (size)
      SZ_HALF:  is_misaligned = ea_lo[0];
      SZ_WORD:  is_misaligned = |ea_lo[1:0];
      SZ_DWORD: is_misaligned = |ea_lo;
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparc_load_align.sv
// sparc_load_align: combinational load-data lane extraction.
//   rdata     - 32-bit word returned by data memory (big-endian)
//   offset    - EA[1:0]; offset 0 selects bits [31:24]
//   size      - access size (byte/half/word; double beats behave as word)
//   is_signed - sign-extend byte/half results
//   data      - extended 32-bit writeback value
module sparc_load_align
  import sparc_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_lane = rdata[31:24];
    unique case (offset)
      2'd0: byte_lane = rdata[31:24];
      2'd1: byte_lane = rdata[23:16];
      2'd2: byte_lane = rdata[15:8];
      2'd3: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];

    data = rdata;
    unique case (size)
      SZ_BYTE: data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{is_signed & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/sparc_load_store_unit.sv
// sparc_load_store_unit: memory-stage responder between decode and writeback.
//   Decode side : in_valid/in_ready, mem_read, mem_write, mem_access_size,
//                 mem_access_signed, src_a/src_b/src_c/src_hi, rd
//   Memory side : dmem_req/we/addr/be/wdata out, dmem_ack/dmem_rdata in
//   Writeback   : wb_valid pulse with wb_rd/wb_data
//   Traps       : trap_valid pulse with trap_cause/trap_addr
// Computes the effective address, checks alignment, drives big-endian byte
// lanes, splits doubles into two word beats and extends load data.
// Optional build macro MEM_TIMEOUT_EN: abandon a beat after TIMEOUT_CYCLES
// cycles without dmem_ack and raise a timeout trap.
module sparc_load_store_unit
  import sparc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_access_size,
  input  logic        mem_access_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] src_c,
  input  logic [31:0] src_hi,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        trap_valid,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_addr
);

  if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, is_load_q, is_load_d, signed_q, signed_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, ea_q, ea_d, hi_q, hi_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  size_q, size_d;
  logic        wb_valid_q, wb_valid_d, trap_valid_q, trap_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d, trap_addr_q, trap_addr_d;
  logic [1:0]  trap_cause_q, trap_cause_d;

  logic        accept, illegal, misalign, ack_seen, timeout_hit;
  logic [31:0] ea_in, load_data;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready & (mem_read | mem_write);
  assign ea_in    = mem_read ? (src_a + src_b) : (src_b + src_c);
  assign illegal  = (mem_read & mem_write) |
                    (mem_read & (mem_access_size == SZ_DWORD) & rd[0]);
  assign misalign = is_misaligned(mem_access_size, ea_in[2:0]);
  assign ack_seen = req_q & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  // Counter reads k on the (k+1)th waiting cycle, so the limit is LIMIT-1.
  assign timeout_hit = req_q & ~dmem_ack & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    to_cnt_d = '0;
    if (req_q && !dmem_ack) to_cnt_d = to_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  sparc_load_align u_align (
    .rdata     (dmem_rdata),
    .offset    (ea_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  // Store lane steering; loads always fetch the whole word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = src_a;
    if (mem_write) begin
      unique case (mem_access_size)
        SZ_BYTE: begin
          st_be    = 4'b1000 >> ea_in[1:0];
          st_wdata = {4{src_a[7:0]}};
        end
        SZ_HALF: begin
          st_be    = ea_in[1] ? 4'b0011 : 4'b1100;
          st_wdata = {2{src_a[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept && !illegal && !misalign) state_d = ST_BEAT0;
      ST_BEAT0: if (ack_seen) state_d = (size_q == SZ_DWORD) ? ST_BEAT1 : ST_IDLE;
                else if (timeout_hit) state_d = ST_IDLE;
      ST_BEAT1: if (ack_seen || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    req_d        = req_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    ea_d         = ea_q;
    hi_d         = hi_q;
    rd_d         = rd_q;
    is_load_d    = is_load_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    trap_valid_d = 1'b0;
    trap_cause_d = trap_cause_q;
    trap_addr_d  = trap_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal || misalign) begin
            trap_valid_d = 1'b1;
            trap_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            trap_addr_d  = ea_in;
          end else begin
            req_d     = 1'b1;
            we_d      = mem_write;
            be_d      = st_be;
            wdata_d   = st_wdata;
            ea_d      = ea_in;
            hi_d      = src_hi;
            rd_d      = rd;
            is_load_d = mem_read;
            size_d    = mem_access_size;
            signed_d  = mem_access_signed;
          end
        end
      end
      default: begin
        if (ack_seen) begin
          req_d = 1'b0;
          if (is_load_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = (state_q == ST_BEAT1) ? (rd_q | 5'd1) : rd_q;
            wb_data_d  = load_data;
          end
          // Set up the odd-word beat; its request rises after one idle cycle.
          if (state_q == ST_BEAT0 && size_q == SZ_DWORD) begin
            ea_d    = ea_q + 32'd4;
            wdata_d = hi_q;
          end
        end else if (timeout_hit) begin
          req_d        = 1'b0;
          trap_valid_d = 1'b1;
          trap_cause_d = CAUSE_TIMEOUT;
          trap_addr_d  = ea_q;
        end else if (!req_q) begin
          req_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      ea_q         <= '0;
      hi_q         <= '0;
      rd_q         <= '0;
      is_load_q    <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      trap_valid_q <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
      trap_addr_q  <= '0;
    end else begin
      req_q        <= req_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      ea_q         <= ea_d;
      hi_q         <= hi_d;
      rd_q         <= rd_d;
      is_load_q    <= is_load_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      trap_valid_q <= trap_valid_d;
      trap_cause_q <= trap_cause_d;
      trap_addr_q  <= trap_addr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {ea_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign trap_valid = trap_valid_q;
  assign trap_cause = trap_cause_q;
  assign trap_addr  = trap_addr_q;

endmodule

// File: tb/tb_sparc_load_store_unit.sv
// Testbench for sparc_load_store_unit: table of single-beat accesses and
// faults, plus hand-written double-word, wait-state, reset and timeout cases.
module tb_sparc_load_store_unit;
  import sparc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_access_size = 2'b00;
  logic        mem_access_signed = 1'b0;
  logic [31:0] src_a = '0, src_b = '0, src_c = '0, src_hi = '0;
  logic [4:0]  rd = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, trap_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, trap_addr;
  logic [1:0]  trap_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sparc_load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_access_size(mem_access_size), .mem_access_signed(mem_access_signed),
    .src_a(src_a), .src_b(src_b), .src_c(src_c), .src_hi(src_hi), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_addr(trap_addr)
  );

  typedef struct {
    string       name;
    logic        rd_f;
    logic        wr_f;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] a, b, c;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_trap;
    logic [1:0]  exp_cause;
    logic [31:0] exp_addr;   // dmem_addr, or trap_addr for faults
    logic [3:0]  exp_be;
    logic [31:0] exp_data;   // store wdata or load writeback value
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] hi, input logic [4:0] d);
    mem_read = r; mem_write = w; mem_access_size = sz; mem_access_signed = sg;
    src_a = a; src_b = b; src_c = c; src_hi = hi; rd = d; in_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.rd_f, v.wr_f, v.size, v.sgn, v.a, v.b, v.c, 32'h0, v.rd);
    check({v.name, " in_ready"}, in_ready, 1);
    @(negedge clk);
    idle_inputs();
    if (v.exp_trap) begin
      check({v.name, " trap_valid"}, trap_valid, 1);
      check({v.name, " trap_cause"}, trap_cause, v.exp_cause);
      check({v.name, " trap_addr"}, trap_addr, v.exp_addr);
      check({v.name, " no req"}, dmem_req, 0);
      @(negedge clk);
      check({v.name, " trap pulse end"}, trap_valid, 0);
      check({v.name, " still no req"}, dmem_req, 0);
    end else begin
      check({v.name, " req"}, dmem_req, 1);
      check({v.name, " addr"}, dmem_addr, v.exp_addr);
      check({v.name, " be"}, dmem_be, v.exp_be);
      check({v.name, " we"}, dmem_we, v.wr_f);
      if (v.wr_f) check({v.name, " wdata"}, dmem_wdata, v.exp_data);
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_ack = 1'b0;
      check({v.name, " req drop"}, dmem_req, 0);
      check({v.name, " wb_valid"}, wb_valid, v.rd_f);
      if (v.rd_f) begin
        check({v.name, " wb_rd"}, wb_rd, v.rd);
        check({v.name, " wb_data"}, wb_data, v.exp_data);
      end
      check({v.name, " ready again"}, in_ready, 1);
      @(negedge clk);
      check({v.name, " wb pulse end"}, wb_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name        rd wr size      sg a             b             c      rd    rdata         trap cause           addr          be       data
    vecs[0]  = '{"ldsb",    1, 0, SZ_BYTE,  1, 32'h100,      32'h3,        32'h0, 5'd5, 32'h123456F0, 0, CAUSE_NONE,     32'h100,      4'b1111, 32'hFFFFFFF0};
    vecs[1]  = '{"ldub",    1, 0, SZ_BYTE,  0, 32'h100,      32'h3,        32'h0, 5'd5, 32'h123456F0, 0, CAUSE_NONE,     32'h100,      4'b1111, 32'h000000F0};
    vecs[2]  = '{"sth",     0, 1, SZ_HALF,  0, 32'hABCD,     32'h200,      32'h2, 5'd0, 32'h0,        0, CAUSE_NONE,     32'h200,      4'b0011, 32'hABCDABCD};
    vecs[3]  = '{"ld_mis",  1, 0, SZ_WORD,  0, 32'h100,      32'h2,        32'h0, 5'd1, 32'h0,        1, CAUSE_MISALIGN, 32'h102,      4'b0000, 32'h0};
    vecs[4]  = '{"stb3",    0, 1, SZ_BYTE,  0, 32'h5A,       32'h100,      32'h3, 5'd0, 32'h0,        0, CAUSE_NONE,     32'h100,      4'b0001, 32'h5A5A5A5A};
    vecs[5]  = '{"ldsh0",   1, 0, SZ_HALF,  1, 32'h400,      32'h0,        32'h0, 5'd9, 32'h87651234, 0, CAUSE_NONE,     32'h400,      4'b1111, 32'hFFFF8765};
    vecs[6]  = '{"ld",      1, 0, SZ_WORD,  1, 32'h500,      32'h4,        32'h0, 5'd2, 32'hDEADBEEF, 0, CAUSE_NONE,     32'h504,      4'b1111, 32'hDEADBEEF};
    vecs[7]  = '{"ldsb0",   1, 0, SZ_BYTE,  1, 32'h600,      32'h0,        32'h0, 5'd4, 32'h7F000000, 0, CAUSE_NONE,     32'h600,      4'b1111, 32'h0000007F};
    vecs[8]  = '{"st",      0, 1, SZ_WORD,  0, 32'hCAFEF00D, 32'h700,      32'h0, 5'd0, 32'h0,        0, CAUSE_NONE,     32'h700,      4'b1111, 32'hCAFEF00D};
    vecs[9]  = '{"rw_ill",  1, 1, SZ_WORD,  0, 32'h10,       32'h20,       32'h10,5'd0, 32'h0,        1, CAUSE_ILLEGAL,  32'h30,       4'b0000, 32'h0};
    vecs[10] = '{"ldd_odd", 1, 0, SZ_DWORD, 0, 32'h300,      32'hC,        32'h0, 5'd7, 32'h0,        1, CAUSE_ILLEGAL,  32'h30C,      4'b0000, 32'h0};
    vecs[11] = '{"sth_mis", 0, 1, SZ_HALF,  0, 32'h1,        32'h200,      32'h1, 5'd0, 32'h0,        1, CAUSE_MISALIGN, 32'h201,      4'b0000, 32'h0};
    vecs[12] = '{"lduh_wr", 1, 0, SZ_HALF,  0, 32'hFFFFFFFE, 32'h4,        32'h0, 5'd8, 32'hAAAA5555, 0, CAUSE_NONE,     32'h0,        4'b1111, 32'h00005555};
    vecs[13] = '{"ldsb1",   1, 0, SZ_BYTE,  1, 32'h800,      32'h1,        32'h0, 5'd3, 32'h00800000, 0, CAUSE_NONE,     32'h800,      4'b1111, 32'hFFFFFF80};
    vecs[14] = '{"std_mis", 0, 1, SZ_DWORD, 0, 32'h0,        32'h300,      32'h4, 5'd0, 32'h0,        1, CAUSE_MISALIGN, 32'h304,      4'b0000, 32'h0};

    // Reset state
    @(negedge clk);
    check("rst dmem_req", dmem_req, 0);
    check("rst dmem_addr", dmem_addr, 0);
    check("rst dmem_be", dmem_be, 0);
    check("rst dmem_wdata", dmem_wdata, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst trap_valid", trap_valid, 0);
    check("rst trap_addr", trap_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);

    // in_valid without read/write is ignored
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd1);
    @(negedge clk);
    idle_inputs();
    check("noop no req", dmem_req, 0);
    check("noop no trap", trap_valid, 0);
    check("noop ready", in_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // ldd, EA=0x308, rd=6, zero-wait beats
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_DWORD, 1'b0, 32'h300, 32'h8, 32'h0, 32'h0, 5'd6);
    @(negedge clk);
    idle_inputs();
    check("ldd b0 req", dmem_req, 1);
    check("ldd b0 addr", dmem_addr, 32'h308);
    check("ldd b0 be", dmem_be, 4'b1111);
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("ldd gap req", dmem_req, 0);
    check("ldd wb0 valid", wb_valid, 1);
    check("ldd wb0 rd", wb_rd, 6);
    check("ldd wb0 data", wb_data, 32'h11111111);
    check("ldd busy", in_ready, 0);
    @(negedge clk);
    check("ldd b1 req", dmem_req, 1);
    check("ldd b1 addr", dmem_addr, 32'h30C);
    check("ldd no wb between", wb_valid, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h22222222;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("ldd end req", dmem_req, 0);
    check("ldd wb1 valid", wb_valid, 1);
    check("ldd wb1 rd", wb_rd, 7);
    check("ldd wb1 data", wb_data, 32'h22222222);
    check("ldd ready", in_ready, 1);

    // Load with two wait states: request and address held until ack
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h500, 32'h10, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    idle_inputs();
    for (int w = 0; w < 2; w++) begin
      check("wait req held", dmem_req, 1);
      check("wait addr held", dmem_addr, 32'h510);
      check("wait no wb", wb_valid, 0);
      @(negedge clk);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h01020304;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("wait wb valid", wb_valid, 1);
    check("wait wb data", wb_data, 32'h01020304);

    // std, reset asserted during beat1 with ack withheld
    @(negedge clk);
    drive(1'b0, 1'b1, SZ_DWORD, 1'b0, 32'hAAAA0001, 32'h900, 32'h8, 32'hBBBB0002, 5'd0);
    @(negedge clk);
    idle_inputs();
    check("std b0 addr", dmem_addr, 32'h908);
    check("std b0 wdata", dmem_wdata, 32'hAAAA0001);
    check("std b0 we", dmem_we, 1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("std no wb", wb_valid, 0);
    @(negedge clk);
    check("std b1 req", dmem_req, 1);
    check("std b1 addr", dmem_addr, 32'h90C);
    check("std b1 wdata", dmem_wdata, 32'hBBBB0002);
    @(negedge clk);
    check("std b1 held", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst mid req", dmem_req, 0);
    check("rst mid wb", wb_valid, 0);
    check("rst mid trap", trap_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post rst ready", in_ready, 1);
      check("post rst req", dmem_req, 0);
      check("post rst wb", wb_valid, 0);
      check("post rst trap", trap_valid, 0);
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4, ack never given
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h4, 32'h0, 32'h0, 5'd2);
    @(negedge clk);
    idle_inputs();
    for (int t = 0; t < 4; t++) begin
      check("to req high", dmem_req, 1);
      check("to no trap yet", trap_valid, 0);
      @(negedge clk);
    end
    check("to req dropped", dmem_req, 0);
    check("to trap valid", trap_valid, 1);
    check("to trap cause", trap_cause, CAUSE_TIMEOUT);
    check("to trap addr", trap_addr, 32'h1004);
    check("to idle", in_ready, 1);
    check("to no wb", wb_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
